input_mapper: RTL and testbench

Parametrised player-input front end for arcade cores. It decodes PS/2 keyboard events into per-player key state and merges them with HPS joystick vectors. It then applies selectable SOCD (opposing-direction) cleaning, stretches coin presses into fixed-length pulses, and toggles a global pause latch. It sits between `hps_io` and the game core, replacing hand-written key registers and OR-merging in each top level. It generalises that logic to 1–4 players and up to 6 buttons.

---
 rtl/input_mapper.sv | 252 +++++++++++++++++++++++++
 tb/tb_input_mapper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_mapper.sv
// Player-input front end: PS/2 key decode, joystick merge, SOCD cleaning,
// coin pulse stretching and a global pause latch for 1-4 players.
module input_mapper #(
  parameter int PLAYERS     = 2,
  parameter int BUTTONS     = 3,
  parameter int COIN_CYCLES = 9600000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                ps2_key,
  input  logic [PLAYERS*16-1:0]      joystick,
  input  logic [1:0]                 socd_mode,
  output logic [PLAYERS*4-1:0]       joy,
  output logic [PLAYERS*BUTTONS-1:0] buttons,
  output logic [PLAYERS-1:0]         start,
  output logic [PLAYERS-1:0]         coin,
  output logic                       pause,
  output logic [PLAYERS*2-1:0]       coin_state_dbg
);

  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_BTN0  = 4;
  localparam int B_START = 10;
  localparam int B_COIN  = 11;
  localparam int B_PAUSE = 12;

  localparam logic [1:0] COIN_IDLE  = 2'd0;
  localparam logic [1:0] COIN_PULSE = 2'd1;
  localparam logic [1:0] COIN_HOLD  = 2'd2;

  localparam int CW = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);

  // Key state is kept in the same bit layout as a joystick vector so the
  // merge is a plain OR. Result is {valid, bit index}.
  function automatic logic [4:0] p1_slot(input logic [7:0] code);
    case (code)
      8'h74:   p1_slot = {1'b1, 4'd0};
      8'h6B:   p1_slot = {1'b1, 4'd1};
      8'h72:   p1_slot = {1'b1, 4'd2};
      8'h75:   p1_slot = {1'b1, 4'd3};
      8'h14:   p1_slot = {1'b1, 4'd4};
      8'h11:   p1_slot = {1'b1, 4'd5};
      8'h29:   p1_slot = {1'b1, 4'd6};
      8'h12:   p1_slot = {1'b1, 4'd7};
      8'h1A:   p1_slot = {1'b1, 4'd8};
      8'h22:   p1_slot = {1'b1, 4'd9};
      8'h16:   p1_slot = {1'b1, 4'd10};
      8'h2E:   p1_slot = {1'b1, 4'd11};
      8'h4D:   p1_slot = {1'b1, 4'd12};
      default: p1_slot = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] p2_slot(input logic [7:0] code);
    case (code)
      8'h34:   p2_slot = {1'b1, 4'd0};
      8'h23:   p2_slot = {1'b1, 4'd1};
      8'h2B:   p2_slot = {1'b1, 4'd2};
      8'h2D:   p2_slot = {1'b1, 4'd3};
      8'h1C:   p2_slot = {1'b1, 4'd4};
      8'h1B:   p2_slot = {1'b1, 4'd5};
      8'h15:   p2_slot = {1'b1, 4'd6};
      8'h1D:   p2_slot = {1'b1, 4'd7};
      8'h24:   p2_slot = {1'b1, 4'd8};
      8'h2C:   p2_slot = {1'b1, 4'd9};
      8'h1E:   p2_slot = {1'b1, 4'd10};
      8'h36:   p2_slot = {1'b1, 4'd11};
      default: p2_slot = 5'd0;
    endcase
  endfunction

  logic        armed;
  logic        prev_tog;
  logic        key_evt;
  logic [4:0]  slot1;
  logic [4:0]  slot2;
  logic [15:0] kb_p1;
  logic [15:0] kb_p2;

  assign key_evt = armed && (ps2_key[10] != prev_tog);
  assign slot1   = p1_slot(ps2_key[7:0]);
  assign slot2   = p2_slot(ps2_key[7:0]);

  // The first edge after reset only captures the toggle bit (arming).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed    <= 1'b0;
      prev_tog <= 1'b0;
      kb_p1    <= '0;
      kb_p2    <= '0;
    end else begin
      armed    <= 1'b1;
      prev_tog <= ps2_key[10];
      if (key_evt && slot1[4]) kb_p1[slot1[3:0]] <= ps2_key[9];
      if (key_evt && slot2[4]) kb_p2[slot2[3:0]] <= ps2_key[9];
    end
  end

  logic [PLAYERS-1:0] pause_vec;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [15:0]        kb;
    logic [15:0]        raw;
    logic               prev_u, prev_d, prev_r, prev_l;
    logic               lat_v, lat_h, lat_v_nxt, lat_h_nxt;
    logic               up_c, down_c, right_c, left_c;
    logic [3:0]         joy_q;
    logic [BUTTONS-1:0] btn_q;
    logic               start_q;
    logic [1:0]         cstate;
    logic [CW-1:0]      ccnt;
    logic               coin_prev;
    logic               coin_q;
    logic               unused_raw;

    if (p == 0) begin : g_kb1
      assign kb = kb_p1;
    end else if (p == 1) begin : g_kb2
      assign kb = kb_p2;
    end else begin : g_kb0
      assign kb = '0;
    end

    assign raw        = joystick[16*p +: 16] | kb;
    assign unused_raw = ^raw;
    assign pause_vec[p] = raw[B_PAUSE];

    // lat_v: 1 = up was latest; lat_h: 1 = right was latest. Same-edge ties favour up/right.
    always_comb begin
      lat_v_nxt = lat_v;
      if (raw[B_UP] && !prev_u)          lat_v_nxt = 1'b1;
      else if (raw[B_DOWN] && !prev_d)   lat_v_nxt = 1'b0;
      lat_h_nxt = lat_h;
      if (raw[B_RIGHT] && !prev_r)       lat_h_nxt = 1'b1;
      else if (raw[B_LEFT] && !prev_l)   lat_h_nxt = 1'b0;

      up_c    = raw[B_UP];
      down_c  = raw[B_DOWN];
      right_c = raw[B_RIGHT];
      left_c  = raw[B_LEFT];
      case (socd_mode)
        2'd1: begin
          if (raw[B_UP] && raw[B_DOWN]) begin
            up_c   = 1'b0;
            down_c = 1'b0;
          end
          if (raw[B_RIGHT] && raw[B_LEFT]) begin
            right_c = 1'b0;
            left_c  = 1'b0;
          end
        end
        2'd2: begin
          if (raw[B_UP] && raw[B_DOWN]) begin
            up_c   = lat_v_nxt;
            down_c = !lat_v_nxt;
          end
          if (raw[B_RIGHT] && raw[B_LEFT]) begin
            right_c = lat_h_nxt;
            left_c  = !lat_h_nxt;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_u  <= 1'b0;
        prev_d  <= 1'b0;
        prev_r  <= 1'b0;
        prev_l  <= 1'b0;
        lat_v   <= 1'b0;
        lat_h   <= 1'b0;
        joy_q   <= '0;
        btn_q   <= '0;
        start_q <= 1'b0;
      end else begin
        prev_u  <= raw[B_UP];
        prev_d  <= raw[B_DOWN];
        prev_r  <= raw[B_RIGHT];
        prev_l  <= raw[B_LEFT];
        lat_v   <= lat_v_nxt;
        lat_h   <= lat_h_nxt;
        joy_q   <= {up_c, down_c, right_c, left_c};
        btn_q   <= raw[B_BTN0 +: BUTTONS];
        start_q <= raw[B_START];
      end
    end

    // Coin edges are only accepted once armed, so a coin held through reset
    // release is treated as already pressed.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cstate    <= COIN_IDLE;
        ccnt      <= '0;
        coin_prev <= 1'b0;
        coin_q    <= 1'b0;
      end else begin
        coin_prev <= raw[B_COIN];
        case (cstate)
          COIN_IDLE: begin
            if (armed && raw[B_COIN] && !coin_prev) begin
              cstate <= COIN_PULSE;
              ccnt   <= COIN_LOAD;
              coin_q <= 1'b1;
            end
          end
          COIN_PULSE: begin
            if (ccnt == '0) begin
              cstate <= COIN_HOLD;
              coin_q <= 1'b0;
            end else begin
              ccnt <= ccnt - CW'(1);
            end
          end
          COIN_HOLD: begin
            if (!raw[B_COIN]) cstate <= COIN_IDLE;
          end
          default: cstate <= COIN_IDLE;
        endcase
      end
    end

    assign joy[4*p +: 4]                 = joy_q;
    assign buttons[BUTTONS*p +: BUTTONS] = btn_q;
    assign start[p]                      = start_q;
    assign coin[p]                       = coin_q;
    assign coin_state_dbg[2*p +: 2]      = cstate;
  end

  logic pause_src;
  logic pause_prev;
  logic unused_top;

  assign pause_src  = |pause_vec;
  assign unused_top = ^{ps2_key[8], kb_p2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause      <= 1'b0;
      pause_prev <= 1'b0;
    end else begin
      pause_prev <= pause_src;
      if (pause_src && !pause_prev) pause <= !pause;
    end
  end

endmodule

// File: tb/tb_input_mapper.sv
// Bench for input_mapper: spec-level model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_input_mapper;
  localparam int PLAYERS     = 4;
  localparam int BUTTONS     = 6;
  localparam int COIN_CYCLES = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [63:0] joystick;
  logic [1:0]  socd_mode;
  logic [15:0] joy;
  logic [23:0] buttons;
  logic [3:0]  start;
  logic [3:0]  coin;
  logic        pause;
  logic [7:0]  coin_state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_mapper #(
    .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .COIN_CYCLES(COIN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .socd_mode(socd_mode), .joy(joy), .buttons(buttons), .start(start),
    .coin(coin), .pause(pause), .coin_state_dbg(coin_state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { logic [7:0] code; int player; int bitpos; } key_map_t;
  key_map_t keymap [25];

  logic [15:0] m_kb [4];
  logic [15:0] m_prev_raw [4];
  int          t_rise [4][4];
  logic        m_coin_on [4];
  int          m_coin_start [4];
  logic        m_coin_hold [4];
  logic        m_armed, m_prev_tog, m_prev_pause;
  int          cyc;
  logic [15:0] exp_joy;
  logic [23:0] exp_buttons;
  logic [3:0]  exp_start, exp_coin;
  logic        exp_pause;

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_kb[p] = '0;
      m_prev_raw[p] = '0;
      for (int d = 0; d < 4; d++) t_rise[p][d] = -1;
      m_coin_on[p] = 1'b0;
      m_coin_start[p] = 0;
      m_coin_hold[p] = 1'b0;
    end
    m_armed = 1'b0; m_prev_tog = 1'b0; m_prev_pause = 1'b0;
    cyc = 0;
    exp_joy = '0; exp_buttons = '0; exp_start = '0; exp_coin = '0; exp_pause = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] raw [4];
    logic r, l, dn, u, c, rose, po;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    po = 1'b0;
    for (int p = 0; p < 4; p++) begin
      raw[p] = joystick[16*p +: 16] | m_kb[p];
      for (int d = 0; d < 4; d++)
        if (raw[p][d] && !m_prev_raw[p][d]) t_rise[p][d] = cyc;
      r = raw[p][0]; l = raw[p][1]; dn = raw[p][2]; u = raw[p][3];
      if (socd_mode == 2'd1) begin
        if (r && l) begin r = 1'b0; l = 1'b0; end
        if (u && dn) begin u = 1'b0; dn = 1'b0; end
      end else if (socd_mode == 2'd2) begin
        if (r && l) begin
          if (t_rise[p][0] >= t_rise[p][1]) l = 1'b0; else r = 1'b0;
        end
        if (u && dn) begin
          if (t_rise[p][3] >= t_rise[p][2]) dn = 1'b0; else u = 1'b0;
        end
      end
      exp_joy[4*p +: 4] = {u, dn, r, l};
      exp_buttons[6*p +: 6] = raw[p][9:4];
      exp_start[p] = raw[p][10];
      // coin: high for COIN_CYCLES edges after an accepted rise, then wait for release
      c = raw[p][11];
      rose = m_armed && c && !m_prev_raw[p][11];
      if (m_coin_on[p] && (cyc - m_coin_start[p] >= COIN_CYCLES)) begin
        m_coin_on[p] = 1'b0;
        m_coin_hold[p] = 1'b1;
      end else if (m_coin_hold[p] && !c) begin
        m_coin_hold[p] = 1'b0;
      end else if (!m_coin_on[p] && !m_coin_hold[p] && rose) begin
        m_coin_on[p] = 1'b1;
        m_coin_start[p] = cyc;
      end
      exp_coin[p] = m_coin_on[p];
      po = po | raw[p][12];
      m_prev_raw[p] = raw[p];
    end
    if (po && !m_prev_pause) exp_pause = !exp_pause;
    m_prev_pause = po;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (ps2_key[10] != m_prev_tog) begin
      for (int k = 0; k < 25; k++)
        if (keymap[k].code == ps2_key[7:0])
          m_kb[keymap[k].player][keymap[k].bitpos] = ps2_key[9];
    end
    m_prev_tog = ps2_key[10];
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("cyc_joy", joy, exp_joy);
    check("cyc_buttons", buttons, exp_buttons);
    check("cyc_start", start, exp_start);
    check("cyc_coin", coin, exp_coin);
    check("cyc_pause", pause, exp_pause);
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_event(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  int cnt, first;

  initial begin
    keymap[0]  = '{8'h74, 0, 0};  keymap[1]  = '{8'h6B, 0, 1};
    keymap[2]  = '{8'h72, 0, 2};  keymap[3]  = '{8'h75, 0, 3};
    keymap[4]  = '{8'h14, 0, 4};  keymap[5]  = '{8'h11, 0, 5};
    keymap[6]  = '{8'h29, 0, 6};  keymap[7]  = '{8'h12, 0, 7};
    keymap[8]  = '{8'h1A, 0, 8};  keymap[9]  = '{8'h22, 0, 9};
    keymap[10] = '{8'h16, 0, 10}; keymap[11] = '{8'h2E, 0, 11};
    keymap[12] = '{8'h4D, 0, 12};
    keymap[13] = '{8'h34, 1, 0};  keymap[14] = '{8'h23, 1, 1};
    keymap[15] = '{8'h2B, 1, 2};  keymap[16] = '{8'h2D, 1, 3};
    keymap[17] = '{8'h1C, 1, 4};  keymap[18] = '{8'h1B, 1, 5};
    keymap[19] = '{8'h15, 1, 6};  keymap[20] = '{8'h1D, 1, 7};
    keymap[21] = '{8'h24, 1, 8};  keymap[22] = '{8'h2C, 1, 9};
    keymap[23] = '{8'h1E, 1, 10}; keymap[24] = '{8'h36, 1, 11};
    model_reset();

    reset = 1'b1; ps2_key = '0; joystick = '0; socd_mode = 2'd0;
    tick(2);
    check("reset_joy", joy, 0);
    check("reset_coin", coin, 0);
    check("reset_pause", pause, 0);
    check("reset_buttons", buttons, 0);

    // toggle held high through reset release: arming edge must not decode it
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    tick(1);
    reset = 1'b0;
    tick(4);
    check("arm_no_event", joy, 0);

    key_event(8'h75, 1'b1);
    tick(1); check("key_up_1cyc", joy[3], 0);
    tick(1); check("key_up_2cyc", joy[3], 1);
    key_event(8'h75, 1'b0);
    tick(2); check("key_up_release", joy[3], 0);
    key_event(8'h4F, 1'b1);
    tick(2); check("key_unmapped", {joy, buttons, start}, 0);

    // key and joystick OR on P1 right
    joystick[0] = 1'b1; tick(1);
    key_event(8'h74, 1'b1); tick(2);
    joystick[0] = 1'b0; tick(2);
    check("or_key_holds", joy[1], 1);
    key_event(8'h74, 1'b0); tick(2);
    check("or_both_released", joy[1], 0);

    // SOCD on P1: left (bit1) then right (bit0); joy[1]=right, joy[0]=left
    joystick[1] = 1'b1; tick(1);
    joystick[0] = 1'b1; tick(2);
    check("socd0", joy[1:0], 2'b11);
    socd_mode = 2'd1; tick(1); check("socd1", joy[1:0], 2'b00);
    socd_mode = 2'd2; tick(1); check("socd2_right_last", joy[1:0], 2'b10);
    joystick[1] = 1'b0; tick(1);
    joystick[1] = 1'b1; tick(1); check("socd2_left_repress", joy[1:0], 2'b01);
    socd_mode = 2'd3; tick(1); check("socd3", joy[1:0], 2'b11);
    joystick[1:0] = 2'b00; tick(1);
    joystick[1:0] = 2'b11; socd_mode = 2'd2; tick(1);
    check("socd2_tie", joy[1:0], 2'b10);
    joystick = '0; tick(1);
    joystick[2] = 1'b1; tick(1);
    joystick[3] = 1'b1; tick(1);
    check("socd2_vert_up_last", joy[3:2], 2'b10);
    socd_mode = 2'd1; tick(1); check("socd1_vert", joy[3:2], 2'b00);
    socd_mode = 2'd0; joystick = '0; tick(2);

    // P2 coin held 20 cycles
    joystick[27] = 1'b1;
    cnt = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (coin[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("coin_len", cnt, 5);
    check("coin_first", first, 1);
    joystick[27] = 1'b0; tick(2);
    joystick[27] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (coin[1]) cnt++;
    end
    check("coin_second_len", cnt, 5);
    joystick[27] = 1'b0; tick(2);

    // pause
    key_event(8'h4D, 1'b1); tick(2); check("pause_key", pause, 1);
    key_event(8'h4D, 1'b0); tick(2);
    joystick[28] = 1'b1; tick(1); check("pause_p2_joy", pause, 0);
    joystick[28] = 1'b0; tick(1);
    key_event(8'h4D, 1'b1); joystick[12] = 1'b1; tick(3);
    check("pause_both", pause, 1);
    key_event(8'h4D, 1'b0); joystick[12] = 1'b0; tick(3);
    check("pause_both_release", pause, 1);

    // merge/width
    joystick[57] = 1'b1; tick(1); check("p4_btn6", buttons[23], 1);
    joystick[57] = 1'b0; tick(1);
    key_event(8'h2C, 1'b1); tick(2); check("p2_btn6_key", buttons[11], 1);
    key_event(8'h2C, 1'b0); tick(2);
    joystick = 64'hE000_E000_E000_E000; tick(2);
    check("hi_bits_ignored", {joy, buttons, start, coin}, 0);
    check("hi_bits_pause", pause, 1);
    joystick = '0; tick(1);

    // async reset mid pulse, coin held through release
    joystick[11] = 1'b1; tick(2);
    check("coin_p1_on", coin[0], 1);
    #2 reset = 1'b1;
    #1 check("coin_async_reset", coin, 0);
    tick(1);
    reset = 1'b0;
    tick(10);
    check("coin_held_reset", coin[0], 0);
    joystick[11] = 1'b0; tick(2);
    joystick[11] = 1'b1; tick(1);
    check("coin_after_release", coin[0], 1);
    joystick[11] = 1'b0; tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
